traffic_req_conditioner: RTL and testbench
==========================================

Name: traffic_req_conditioner

Overview:
Upstream stage of the traffic-light fsm. Takes raw, asynchronous, bouncy north/west car-sensor inputs and synchronizes and debounces them. It then holds each qualified request as a steady level on n/w until the fsm's light output shows that direction served. It also flags requests that wait too long.

Parameters:
DEB_CYCLES, 4, consecutive high synchronized samples needed to qualify a request (>=2)
CNT_W, 3, debounce counter width; must hold DEB_CYCLES-1
TIMEOUT, 64, cycles a request may stay pending before starve flag sets
TO_W, 7, timeout counter width; must hold TIMEOUT
LIGHT_N, 2'b01, light code meaning north green (north served)
LIGHT_W, 2'b10, light code meaning west green (west served)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
raw_n  input  1  north car sensor, asynchronous, may bounce
raw_w  input  1  west car sensor, asynchronous, may bounce
light  input  2  current light state fed back from fsm
n  output  1  qualified north request to fsm, level
w  output  1  qualified west request to fsm, level
starve_n  output  1  sticky: north request pending >= TIMEOUT cycles
starve_w  output  1  sticky: west request pending >= TIMEOUT cycles

Behaviour:
- Reset (reset=0, async): sync flops, counters and states clear. Both channels go to IDLE. n=w=starve_n=starve_w=0 immediately. Deassertion is taken at the next clk edge.
- Sync: 2-flop synchronizer per raw input. The debounce FSM sees only the second flop (s).
- Two identical, independent per-channel FSMs, each registered with outputs decoded from state:
  - IDLE: req=0. s=1 -> QUAL with cnt=1.
  - QUAL: req=0. s=0 -> IDLE, cnt=0. s=1 and cnt==DEB_CYCLES-1 -> PEND. Otherwise cnt++.
  - PEND: req=1, timeout counter increments and saturates at TIMEOUT. light==serve code -> SERVED. Counter reaching TIMEOUT sets the channel's starve flag.
  - SERVED: req=0. s=0 -> IDLE. Otherwise stay; a car must leave before it can re-request.
- Latency: raw high setup before edge 1 gives s=1 at edge 2 and QUAL at edge 3. PEND is entered and req=1 after edge DEB_CYCLES+2 (edge 6 at default).
- Glitch rule: any s low sample during QUAL aborts to IDLE. A raw pulse that gives fewer than DEB_CYCLES consecutive high s samples produces no request.
- Service: the PEND->SERVED transition occurs on the edge where light==serve code. req drops the same edge, so the fsm sees at most one extra cycle of req after granting.
- If light already equals the serve code when QUAL completes, the channel goes QUAL->PEND. It then goes PEND->SERVED on the next edge, giving a 1-cycle req pulse.
- Simultaneous: both channels may be PEND together. Both n and w are asserted; arbitration belongs to the fsm.
- light codes other than LIGHT_N/LIGHT_W (e.g. 2'b00, 2'b11) serve neither channel.
- Starve flags are sticky until reset. Leaving PEND clears the timeout counter but not the flag.
- Mid-operation reset: all state is lost and the outputs drop asynchronously. No request is remembered across reset.

Test Plan:
- Reset: hold reset=0 with raw_n=raw_w=1 -> n=w=starve_*=0 throughout. Release reset, then n rises after edge 6 following release, with light=00.
- Debounce: raw_n high for 3 cycles then low -> n never asserts. raw_n high 4+ cycles -> n=1 after edge 6, held while light=00.
- Service: north PEND, drive light=2'b01 -> n=0 on that edge. With raw_n still 1, n stays 0. After raw_n low for 3 cycles and high again for 4+, n reasserts.
- Cross-service: west PEND, light=2'b01 for 5 cycles -> w stays 1. light=2'b10 -> w=0 next edge.
- Simultaneous: raw_n and raw_w rise the same cycle -> n and w both 1 after edge 6. light=01 clears only n; w remains 1 until light=10.
- Starve: west PEND with light=00 for 64 cycles -> starve_w=1 at the 64th cycle in PEND. It stays 1 after service until async reset asserts.

Source files
------------

// File: rtl/traffic_req_conditioner.sv
// traffic_req_conditioner
// Front end of the traffic-light controller. Each car sensor is synchronized
// and debounced, then presented to the light FSM as a steady request level
// until the fed-back light shows that direction green. A sticky starve flag
// marks requests that have waited TIMEOUT cycles.

// One sensor channel: synchronizer, debounce/hold FSM and starvation timer.
module traffic_req_conditioner_chan #(
    parameter int         DEB_CYCLES = 4,
    parameter int         CNT_W      = 3,
    parameter int         TIMEOUT    = 64,
    parameter int         TO_W       = 7,
    parameter logic [1:0] SERVE_CODE = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw,
    input  logic [1:0] light,
    output logic       req,
    output logic       starve
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        PEND   = 2'd2,
        SERVED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    state_t           state;
    logic             s1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;

    // Two-flop synchronizer; only s is allowed to reach the FSM.
    // NOTE: the raw sensor may change at any time, so it must never feed
    // decision logic directly; s1 absorbs metastability, s is the clean copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make s take the old s1, which is
            // what builds the two-stage pipeline; blocking would collapse it.
            s1 <= raw;
            s  <= s1;
        end
    end

    // Debounce, request hold and starvation timing for this direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            to_cnt <= '0;
            starve <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= QUAL;
                        cnt   <= CNT_ONE;
                    end
                end
                QUAL: begin
                    // Any low sample while qualifying is treated as bounce.
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= PEND;
                        cnt    <= '0;
                        to_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PEND: begin
                    // Service wins over the timer on the same edge.
                    if (light == SERVE_CODE) begin
                        state  <= SERVED;
                        to_cnt <= '0;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + TO_ONE;
                        if (to_cnt == TO_MAX - TO_ONE) begin
                            starve <= 1'b1;
                        end
                    end
                end
                SERVED: begin
                    // The car has to leave before a new request can start.
                    if (!s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request is a pure decode of the state register, so it is glitch-free.
    assign req = (state == PEND);

endmodule

// Top: two identical, independent channels; arbitration is left to the FSM.
module traffic_req_conditioner #(
    parameter int         DEB_CYCLES = 4,
    parameter int         CNT_W      = 3,
    parameter int         TIMEOUT    = 64,
    parameter int         TO_W       = 7,
    parameter logic [1:0] LIGHT_N    = 2'b01,
    parameter logic [1:0] LIGHT_W    = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_n,
    input  logic       raw_w,
    input  logic [1:0] light,
    output logic       n,
    output logic       w,
    output logic       starve_n,
    output logic       starve_w
);

    traffic_req_conditioner_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .TO_W       (TO_W),
        .SERVE_CODE (LIGHT_N)
    ) u_north (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_n),
        .light  (light),
        .req    (n),
        .starve (starve_n)
    );

    traffic_req_conditioner_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .TO_W       (TO_W),
        .SERVE_CODE (LIGHT_W)
    ) u_west (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_w),
        .light  (light),
        .req    (w),
        .starve (starve_w)
    );

endmodule

// File: tb/tb_traffic_req_conditioner.sv
// Bench for traffic_req_conditioner: directed scenarios followed by random
// sensor/light traffic, all compared every cycle against a behavioural model.
module tb_traffic_req_conditioner;

    localparam int         DEB_CYCLES = 4;
    localparam int         TIMEOUT    = 64;
    localparam logic [1:0] LIGHT_N    = 2'b01;
    localparam logic [1:0] LIGHT_W    = 2'b10;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       raw_n = 1'b0;
    logic       raw_w = 1'b0;
    logic [1:0] light = 2'b00;
    logic       n;
    logic       w;
    logic       starve_n;
    logic       starve_w;

    int vectors     = 0;
    int miscompares = 0;

    traffic_req_conditioner dut (
        .clk      (clk),
        .reset    (reset),
        .raw_n    (raw_n),
        .raw_w    (raw_w),
        .light    (light),
        .n        (n),
        .w        (w),
        .starve_n (starve_n),
        .starve_w (starve_w)
    );

    always #5 clk = ~clk;

    // Behavioural model, index 0 = north, 1 = west. A request is described by
    // the length of the current run of high synchronized samples, whether a
    // request is outstanding, whether the car is still parked after service,
    // and how long the outstanding request has waited.
    bit m_s1[2];
    bit m_s[2];
    bit m_pend[2];
    bit m_lock[2];
    bit m_starve[2];
    int m_run[2];
    int m_wait[2];

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s[c] = 1'b0; m_pend[c] = 1'b0; m_lock[c] = 1'b0;
            m_starve[c] = 1'b0; m_run[c] = 0; m_wait[c] = 0;
        end
    endfunction

    // One rising clock edge as seen by the model, using the driven inputs.
    function automatic void model_edge();
        bit raw_c;
        bit serve;
        if (!reset) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            raw_c = (c == 0) ? raw_n : raw_w;
            serve = (light == ((c == 0) ? LIGHT_N : LIGHT_W));
            if (m_pend[c]) begin
                if (serve) begin
                    m_pend[c] = 1'b0;
                    m_lock[c] = 1'b1;
                    m_wait[c] = 0;
                end else begin
                    if (m_wait[c] < TIMEOUT) m_wait[c]++;
                    if (m_wait[c] == TIMEOUT) m_starve[c] = 1'b1;
                end
            end else if (m_lock[c]) begin
                if (!m_s[c]) m_lock[c] = 1'b0;
            end else if (m_s[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB_CYCLES) begin
                    m_pend[c] = 1'b1;
                    m_run[c]  = 0;
                    m_wait[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_s[c]  = m_s1[c];
            m_s1[c] = raw_c;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check($sformatf("%s.n", tag),        n,        m_pend[0]);
        check($sformatf("%s.w", tag),        w,        m_pend[1]);
        check($sformatf("%s.starve_n", tag), starve_n, m_starve[0]);
        check($sformatf("%s.starve_w", tag), starve_w, m_starve[1]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int k, input string tag);
        repeat (k) step(tag);
    endtask

    // Asserts reset between edges; outputs must drop without a clock.
    task automatic reset_low(input string tag);
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs(tag);
    endtask

    initial begin
        int hold_n;
        int hold_w;
        int hold_l;

        // Reset held with both sensors active: nothing may leak out.
        model_clear();
        raw_n = 1'b1; raw_w = 1'b1; light = 2'b00;
        #1;
        check_outputs("rst_hold");
        run(4, "rst_hold");

        // First request after release: edge 6.
        reset = 1'b1;
        run(5, "latency");
        check("lat_edge5_n", n, 1'b0);
        step("latency");
        check("lat_edge6_n", n, 1'b1);
        check("lat_edge6_w", w, 1'b1);
        reset_low("rst_mid");
        run(2, "rst_mid");
        raw_n = 1'b0; raw_w = 1'b0;
        reset = 1'b1;
        run(3, "idle");

        // Short pulse is rejected, long one qualifies and is held.
        raw_n = 1'b1;
        run(3, "deb_short");
        raw_n = 1'b0;
        run(8, "deb_short");
        check("deb_short_n", n, 1'b0);
        raw_n = 1'b1;
        run(6, "deb_long");
        check("deb_long_n", n, 1'b1);
        run(5, "deb_hold");

        // Service, car parked, car leaves and returns.
        light = LIGHT_N;
        step("serve_n");
        check("serve_n_drop", n, 1'b0);
        light = 2'b00;
        run(4, "serve_park");
        raw_n = 1'b0;
        run(3, "leave_n");
        raw_n = 1'b1;
        run(6, "rereq_n");
        check("rereq_n", n, 1'b1);
        light = LIGHT_N;
        step("serve_n2");
        light = 2'b00; raw_n = 1'b0;
        run(4, "idle");

        // Cross-service: north green does nothing for west; 11 serves nobody.
        raw_w = 1'b1;
        run(6, "cross");
        light = LIGHT_N;
        run(5, "cross");
        check("cross_hold_w", w, 1'b1);
        light = 2'b11;
        run(2, "code11");
        light = LIGHT_W;
        step("serve_w");
        check("serve_w_drop", w, 1'b0);
        light = 2'b00; raw_w = 1'b0;
        run(4, "idle");

        // Simultaneous requests.
        raw_n = 1'b1; raw_w = 1'b1;
        run(6, "simul");
        check("simul_n", n, 1'b1);
        check("simul_w", w, 1'b1);
        light = LIGHT_N;
        step("simul_sn");
        check("simul_sn_w", w, 1'b1);
        light = 2'b00;
        run(3, "simul");
        light = LIGHT_W;
        step("simul_sw");
        light = 2'b00; raw_n = 1'b0; raw_w = 1'b0;
        run(4, "idle");

        // Starvation: flag appears on the 64th edge spent pending.
        raw_w = 1'b1;
        run(6, "starve");
        run(TIMEOUT - 1, "starve");
        check("starve_pre", starve_w, 1'b0);
        step("starve");
        check("starve_set", starve_w, 1'b1);
        light = LIGHT_W;
        step("starve_srv");
        light = 2'b00;
        run(3, "starve_stk");
        check("starve_sticky", starve_w, 1'b1);
        reset_low("starve_rst");
        run(2, "starve_rst");
        raw_w = 1'b0;
        reset = 1'b1;
        run(3, "idle");

        // Random bouncy sensors, random light codes, occasional reset.
        hold_n = 1; hold_w = 1; hold_l = 1;
        for (int i = 0; i < 4000; i++) begin
            if (--hold_n == 0) begin
                raw_n  = 1'($urandom_range(0, 1));
                hold_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 120))
                                                     : int'($urandom_range(1, 6));
            end
            if (--hold_w == 0) begin
                raw_w  = 1'($urandom_range(0, 1));
                hold_w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 120))
                                                     : int'($urandom_range(1, 6));
            end
            if (--hold_l == 0) begin
                light  = 2'($urandom_range(0, 3));
                hold_l = int'($urandom_range(1, 40));
            end
            if ($urandom_range(0, 799) == 0) begin
                reset_low("rand_rst");
                run(int'($urandom_range(1, 3)), "rand_rst");
                reset = 1'b1;
            end
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
